// File: rtl/pedal_pkg.sv
// Shared types and constants for the pedal filter datapath.
package pedal_pkg;

  typedef logic signed [11:0] sample_t;

  // Q1.11 value closest to +1.0; a kernel holding only this tap is pass-through.
  localparam sample_t KERNEL_UNITY = 12'h7FF;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    CHECK,
    PENDING
  } loader_state_t;

endpackage

// File: rtl/kernel_bank.sv
// Shadow coefficient register file with an indexed write port and an
// atomic parallel commit of every tap into the active kernel register set.
module kernel_bank
  import pedal_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         clear,
  input  logic                         commit,
  output logic [DEPTH-1:0][WIDTH-1:0]  kernel
);

  logic signed [WIDTH-1:0] shadow [DEPTH];

  // Shadow bank: written one tap at a time, wiped on reset or a discarded load.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < DEPTH; i++) shadow[i] <= '0;
    end else if (wr_en) begin
      shadow[wr_idx] <= wr_data;
    end
  end

  // Active kernel: every tap replaced on the same edge so the filter never sees a mix.
  always_ff @(posedge clk) begin
    if (reset) begin
      kernel    <= '0;
      kernel[0] <= WIDTH'(KERNEL_UNITY);
    end else if (commit) begin
      for (int i = 0; i < DEPTH; i++) kernel[i] <= shadow[i];
    end
  end

endmodule

// File: rtl/kernel_loader.sv
// Filter kernel loader: accepts DEPTH coefficients over valid/ready into a
// shadow bank and swaps them into the active kernel on the next update strobe.
// Optional feature macro: KERNEL_CHECKSUM_EN (adds a trailing checksum word).
module kernel_loader
  import pedal_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_start,
  input  logic                         load_abort,
  input  logic [WIDTH-1:0]             coef_in,
  input  logic                         coef_valid,
  output logic                         coef_ready,
  input  logic                         update,
  output logic [DEPTH-1:0][WIDTH-1:0]  kernel,
  output logic                         kernel_swap,
  output logic                         busy,
  output logic                         err_checksum
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  loader_state_t    state, state_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic             xfer;
  logic             bank_we, bank_clr, bank_commit;

`ifdef KERNEL_CHECKSUM_EN
  logic [WIDTH-1:0] acc, acc_next;
  logic             err_next;
`endif

  assign xfer = coef_valid && coef_ready;

  // Next-state logic: abort beats restart, restart beats normal progress.
  always_comb begin
    state_next  = state;
    idx_next    = idx;
    bank_we     = 1'b0;
    bank_clr    = 1'b0;
    bank_commit = 1'b0;
`ifdef KERNEL_CHECKSUM_EN
    acc_next    = acc;
    err_next    = 1'b0;
`endif
    if (load_abort) begin
      state_next = IDLE;
      idx_next   = '0;
    end else if (load_start) begin
      state_next = FILL;
      idx_next   = '0;
`ifdef KERNEL_CHECKSUM_EN
      acc_next   = '0;
`endif
    end else begin
      case (state)
        FILL: begin
          if (xfer) begin
            bank_we = 1'b1;
`ifdef KERNEL_CHECKSUM_EN
            acc_next = acc + coef_in;
`endif
            if (idx == LAST) begin
`ifdef KERNEL_CHECKSUM_EN
              state_next = CHECK;
`else
              state_next = PENDING;
`endif
            end else begin
              idx_next = idx + 1'b1;
            end
          end
        end
`ifdef KERNEL_CHECKSUM_EN
        CHECK: begin
          if (xfer) begin
            if (coef_in == acc) begin
              state_next = PENDING;
            end else begin
              err_next   = 1'b1;
              bank_clr   = 1'b1;
              state_next = IDLE;
              idx_next   = '0;
            end
          end
        end
`endif
        PENDING: begin
          if (update) begin
            bank_commit = 1'b1;
            state_next  = IDLE;
            idx_next    = '0;
          end
        end
        default: begin
          state_next = state;
        end
      endcase
    end
  end

  // Control registers; handshake and status outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      coef_ready  <= 1'b0;
      busy        <= 1'b0;
      kernel_swap <= 1'b0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      coef_ready  <= (state_next == FILL) || (state_next == CHECK);
      busy        <= (state_next != IDLE);
      kernel_swap <= bank_commit;
    end
  end

`ifdef KERNEL_CHECKSUM_EN
  // Running modulo-2^WIDTH checksum and its one-cycle mismatch flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc          <= '0;
      err_checksum <= 1'b0;
    end else begin
      acc          <= acc_next;
      err_checksum <= err_next;
    end
  end
`else
  assign err_checksum = 1'b0;
`endif

  kernel_bank #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bank_we),
    .wr_idx  (idx),
    .wr_data (coef_in),
    .clear   (bank_clr),
    .commit  (bank_commit),
    .kernel  (kernel)
  );

endmodule

// File: tb/tb_kernel_loader.sv
// Self-checking bench for kernel_loader: directed cases plus randomized
// load/abort/restart transactions against a transaction-level kernel model.
// Honours KERNEL_CHECKSUM_EN when the design is built with it.
module tb_kernel_loader;

  localparam int DEPTH = 8;
  localparam int WIDTH = 12;

  logic clk = 1'b0;
  logic reset, load_start, load_abort, coef_valid, update;
  logic [WIDTH-1:0] coef_in;
  logic coef_ready, kernel_swap, busy, err_checksum;
  logic [DEPTH-1:0][WIDTH-1:0] kernel;

  int checks = 0;
  int failures = 0;
  int swaps = 0;

  logic [WIDTH-1:0] act  [DEPTH];
  logic [WIDTH-1:0] wbuf [DEPTH];

  kernel_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .load_abort   (load_abort),
    .coef_in      (coef_in),
    .coef_valid   (coef_valid),
    .coef_ready   (coef_ready),
    .update       (update),
    .kernel       (kernel),
    .kernel_swap  (kernel_swap),
    .busy         (busy),
    .err_checksum (err_checksum)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (kernel_swap === 1'b1) swaps++;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DEPTH*WIDTH-1:0] model_kernel();
    logic [DEPTH*WIDTH-1:0] r;
    for (int i = 0; i < DEPTH; i++) r[i*WIDTH +: WIDTH] = act[i];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] csum();
    logic [WIDTH-1:0] s = '0;
    for (int i = 0; i < DEPTH; i++) s = s + wbuf[i];
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) act[i] = '0;
    act[0] = 12'h7FF;
  endtask

  // One word over the handshake, with random idle gaps (update toggled there harmlessly).
  task automatic send(input logic [WIDTH-1:0] w, input bit with_update);
    int n = 0;
    repeat ($urandom_range(0, 2)) begin
      coef_valid = 1'b0;
      update     = 1'($urandom_range(0, 1));
      tick();
    end
    update     = with_update;
    coef_valid = 1'b1;
    coef_in    = w;
    while (!coef_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("ready_timeout", 1'b0, 1'b1);
    tick();
    coef_valid = 1'b0;
    update     = 1'b0;
    coef_in    = WIDTH'($urandom);
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("start_busy", busy, 1'b1);
    chk("start_ready", coef_ready, 1'b1);
  endtask

  task automatic send_all(input bit coincide);
`ifdef KERNEL_CHECKSUM_EN
    for (int i = 0; i < DEPTH; i++) send(wbuf[i], 1'b0);
    send(csum(), coincide);
`else
    for (int i = 0; i < DEPTH; i++) send(wbuf[i], coincide && (i == DEPTH - 1));
`endif
  endtask

  // Complete load of wbuf; update after gap cycles; model swaps on that update.
  task automatic full_load(input int gap, input bit coincide);
    int s0;
    logic [DEPTH*WIDTH-1:0] old;
    s0  = swaps;
    old = model_kernel();
    pulse_start();
    send_all(coincide);
    chk("pend_busy", busy, 1'b1);
    chk("pend_ready", coef_ready, 1'b0);
    chk("pend_kernel", kernel, old);
    if (coincide) chk("coinc_noswap", kernel_swap, 1'b0);
    repeat (gap) begin
      coef_valid = 1'($urandom_range(0, 1));
      coef_in    = WIDTH'($urandom);
      tick();
    end
    coef_valid = 1'b0;
    chk("wait_kernel", kernel, old);
    chk("wait_ready", coef_ready, 1'b0);
    update = 1'b1;
    tick();
    update = 1'b0;
    for (int i = 0; i < DEPTH; i++) act[i] = wbuf[i];
    chk("swap_kernel", kernel, model_kernel());
    chk("swap_pulse", kernel_swap, 1'b1);
    chk("swap_busy", busy, 1'b0);
    tick();
    chk("swap_pulse_end", kernel_swap, 1'b0);
    chk("swap_count", 32'(swaps - s0), 32'd1);
  endtask

  task automatic aborted_load(input int k);
    int s0;
    s0 = swaps;
    pulse_start();
    for (int i = 0; i < k; i++) send(WIDTH'($urandom), 1'b0);
    load_abort = 1'b1;
    load_start = 1'($urandom_range(0, 1));
    tick();
    load_abort = 1'b0;
    load_start = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", coef_ready, 1'b0);
    update = 1'b1;
    tick();
    update = 1'b0;
    tick();
    chk("abort_kernel", kernel, model_kernel());
    chk("abort_noswap", 32'(swaps - s0), 32'd0);
  endtask

  task automatic pending_abort();
    int s0;
    s0 = swaps;
    pulse_start();
    send_all(1'b0);
    load_abort = 1'b1;
    update     = 1'b1;
    tick();
    load_abort = 1'b0;
    update     = 1'b0;
    chk("pabort_kernel", kernel, model_kernel());
    chk("pabort_swap", kernel_swap, 1'b0);
    chk("pabort_busy", busy, 1'b0);
    tick();
    chk("pabort_count", 32'(swaps - s0), 32'd0);
  endtask

  task automatic rand_words();
    for (int i = 0; i < DEPTH; i++) wbuf[i] = WIDTH'($urandom);
  endtask

  initial begin
    reset = 1'b1; load_start = 1'b0; load_abort = 1'b0;
    coef_valid = 1'b0; update = 1'b0; coef_in = '0;
    model_reset();
    tick();
    tick();
    chk("rst_kernel", kernel, model_kernel());
    chk("rst_ready", coef_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_swap", kernel_swap, 1'b0);
    chk("rst_err", err_checksum, 1'b0);
    reset = 1'b0;
    tick();

    // Abort after five words leaves the unity kernel.
    aborted_load(5);

    // Restart after three words, then a full load of 0x100..0x107.
    pulse_start();
    for (int i = 0; i < 3; i++) send(WIDTH'($urandom), 1'b0);
    for (int i = 0; i < DEPTH; i++) wbuf[i] = WIDTH'(12'h100 + i);
    full_load(2, 1'b0);
    chk("restart_tap0", kernel[0], 12'h100);

    // Normal load 1..8, update three cycles after the last transfer.
    for (int i = 0; i < DEPTH; i++) wbuf[i] = WIDTH'(i + 1);
    full_load(3, 1'b0);
    for (int i = 0; i < DEPTH; i++) chk("normal_tap", kernel[i], WIDTH'(i + 1));

    // Final transfer coincident with update: swap only on the later update.
    rand_words();
    full_load(47, 1'b1);

    // Backpressure in IDLE: words ignored, load afterwards lands in order.
    coef_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      coef_in = WIDTH'($urandom);
      tick();
      chk("idle_ready", coef_ready, 1'b0);
    end
    coef_valid = 1'b0;
    rand_words();
    full_load(4, 1'b0);

    // Abort beats an update seen in PENDING.
    rand_words();
    pending_abort();

    // Reset mid-load restores the unity kernel.
    pulse_start();
    for (int i = 0; i < 4; i++) send(WIDTH'($urandom), 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
    chk("midrst_kernel", kernel, model_kernel());
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", coef_ready, 1'b0);
    tick();

`ifdef KERNEL_CHECKSUM_EN
    // Checksum mismatch discards the load and pulses err_checksum.
    for (int i = 0; i < DEPTH; i++) wbuf[i] = WIDTH'(i + 1);
    chk("csum_value", csum(), 12'h024);
    pulse_start();
    for (int i = 0; i < DEPTH; i++) send(wbuf[i], 1'b0);
    send(12'h025, 1'b0);
    chk("csum_err", err_checksum, 1'b1);
    chk("csum_busy", busy, 1'b0);
    update = 1'b1;
    tick();
    update = 1'b0;
    chk("csum_err_end", err_checksum, 1'b0);
    chk("csum_kernel", kernel, model_kernel());
    chk("csum_noswap", kernel_swap, 1'b0);
    full_load(2, 1'b0);
`endif

    // Randomized transactions.
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          rand_words();
          full_load($urandom_range(0, 6), 1'($urandom_range(0, 1)));
        end
        1: aborted_load($urandom_range(0, DEPTH - 1));
        2: begin
          pulse_start();
          repeat ($urandom_range(0, DEPTH - 1)) send(WIDTH'($urandom), 1'b0);
          rand_words();
          full_load($urandom_range(0, 4), 1'b0);
        end
        default: begin
          rand_words();
          pending_abort();
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kernel_loader.md
Name: kernel_loader

Overview:
- Write side of the filter kernel bus. Accepts filter coefficients one word at a time over a valid/ready handshake into a shadow bank.
- Commits the full bank to the active `kernel` output atomically on a sample `update` strobe, so the convolution stage never computes with a half-written kernel.
- Sits between the control/UI logic (preset selection, coefficient ROM or host link) and the convolution filter's `kernel` input.

Parameters:
- DEPTH, 8, number of taps; must match the filter's DEPTH.
- WIDTH, 12, coefficient width, signed Q1.11.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- load_start  in  1  one-cycle pulse: begin a new kernel load
- load_abort  in  1  one-cycle pulse: discard the load in progress
- coef_in  in  WIDTH  coefficient word; tap 0 is sent first
- coef_valid  in  1  coef_in is valid
- coef_ready  out  1  loader accepts coef_in this cycle
- update  in  1  sample strobe, same signal that clocks the filter history
- kernel  out  DEPTH*WIDTH  active kernel, packed [DEPTH-1:0][WIDTH-1:0]
- kernel_swap  out  1  one-cycle pulse: active kernel was replaced
- busy  out  1  a load is in FILL or PENDING
- err_checksum  out  1  one-cycle pulse on checksum mismatch (optional feature)

Behaviour:
- Reset values:
  - state=IDLE, index=0, shadow=0.
  - kernel tap 0 = KERNEL_UNITY (12'h7FF), all other taps = 0, so the filter is pass-through.
  - coef_ready=0, kernel_swap=0, busy=0, err_checksum=0.
- States and transitions:
  - IDLE: coef_ready=0. On load_start: go to FILL, index<=0.
  - FILL: coef_ready=1.
    - A transfer is coef_valid&&coef_ready: shadow[index]<=coef_in, index++.
    - The transfer with index==DEPTH-1 moves to PENDING (or CHECK when the optional feature is compiled in).
  - PENDING: coef_ready=0.
    - On update: kernel<=shadow (all taps on the same edge), kernel_swap=1 on the following cycle only, go to IDLE.
- Registered outputs: coef_ready and busy are registered, derived from the state.
- Swap latency: the kernel changes on the first update edge seen while in PENDING.
  - If update is high on the same edge as the final coefficient transfer, that update is NOT used.
  - The swap waits for the next update.
- Boundary cases:
  - load_start in FILL or PENDING restarts the load: index<=0, go to FILL, shadow content is overwritten. The active kernel is untouched.
  - load_abort in any state goes to IDLE, index<=0. The active kernel is untouched. load_abort wins over a simultaneous load_start.
  - load_abort on the same edge as a PENDING update: abort wins, no swap.
  - coef_valid while coef_ready=0: the word is ignored, with no error.
  - index never wraps. Its width is $clog2(DEPTH), and it saturates at DEPTH-1 on leaving FILL.
  - update outside PENDING has no effect.
  - reset mid-load returns to the reset values, including the unity kernel.

Optional Feature:
- Macro: KERNEL_CHECKSUM_EN.
- With the macro defined:
  - After tap DEPTH-1 the FSM enters CHECK (coef_ready=1) and accepts one extra word.
  - The extra word must equal the modulo-2^WIDTH sum of the DEPTH coefficients, computed with a running accumulator during FILL.
  - On match: go to PENDING.
  - On mismatch: err_checksum=1 for one cycle, shadow is discarded, go to IDLE.
  - load_start and load_abort apply in CHECK exactly as in FILL.
- Without the macro: there is no CHECK state, PENDING follows FILL directly, and err_checksum is tied 0.

Decomposition:
- Shared package pedal_pkg holds:
  - typedef sample_t (logic signed [11:0]);
  - constant KERNEL_UNITY = 12'h7FF;
  - enum loader_state_t {IDLE, FILL, CHECK, PENDING}.
- One sub-module, kernel_bank: the DEPTH-entry shadow register file with an indexed write port plus a parallel commit into the active register set on a commit strobe.
- The FSM, index counter and checksum accumulator stay in kernel_loader.

Test Plan:
- Reset: hold reset 2 cycles -> kernel={0,...,0,12'h7FF} (tap0=7FF), coef_ready=0, busy=0.
- Normal load:
  - Stimulus: load_start, then 8 words 12'h001..12'h008 with coef_valid held 1, then update pulsed 3 cycles after the last transfer.
  - Response: kernel unchanged until the update edge; then tap i = i+1; kernel_swap high exactly 1 cycle; busy back to 0.
- Last transfer coincident with update:
  - Response: no swap on that edge; the swap happens on the next update, 48 cycles later.
- Abort and restart:
  - Abort: after 5 words, pulse load_abort -> state IDLE, kernel still unity, kernel_swap never asserts.
  - Restart: load_start after 3 words, then 8 new words 12'h100..12'h107 plus update -> kernel tap0=12'h100.
- Backpressure: drive coef_valid in IDLE and PENDING -> no index change, coef_ready=0.
- Checksum (KERNEL_CHECKSUM_EN):
  - Words 12'h001..12'h008 then 12'h024 -> swap on update.
  - Same words then 12'h025 -> err_checksum pulse, no swap, kernel still unity.
